// File: rtl/ch_collect_if.sv
// Sweep/sample bus from the channel selector plus the write port into the sample FIFO.
// Optional CH_COLLECT_TAG_EN widens fifo_data by 3 bits to carry the channel index.
interface ch_collect_if #(
  parameter int WIDTH = 16
);
`ifdef CH_COLLECT_TAG_EN
  localparam int DW = WIDTH + 3;
`else
  localparam int DW = WIDTH;
`endif

  // Handshake: req_data/sel_in/sample form one beat per cycle with no ready; the
  // collector may only refuse via fifo_full sampled on the same edge. fifo_wr is a
  // one-cycle strobe per word; frame_start qualifies fifo_wr on channel 0.
  logic          req_data;
  logic [2:0]    sel_in;
  logic [WIDTH-1:0] sample;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data;
  logic          frame_start;

  modport master (
    output req_data, sel_in, sample, fifo_full,
    input  fifo_wr, fifo_data, frame_start
  );

  modport slave (
    input  req_data, sel_in, sample, fifo_full,
    output fifo_wr, fifo_data, frame_start
  );
endinterface

// File: rtl/ch_collect.sv
// Collects one sample per channel of each selector sweep into the sample FIFO, keeping frames aligned.
// Optional CH_COLLECT_TAG_EN: fifo_data carries {sel_in, sample}.
module ch_collect #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       channels,
  input  logic             err_clr,
  ch_collect_if.slave      bus,
  output logic             overrun,
  output logic             seq_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [1:0]       dbg_state
);
`ifdef CH_COLLECT_TAG_EN
  localparam int DW = WIDTH + 3;
`else
  localparam int DW = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic             armed_q, armed_d;
  logic             wr_q, wr_d;
  logic             fs_q, fs_d;
  logic [DW-1:0]    data_q, data_d;
  logic             ovr_q, ovr_d;
  logic             seq_q, seq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start, ovr_set, seq_set, cnt_inc;
  logic [DW-1:0]    word;

`ifdef CH_COLLECT_TAG_EN
  assign word = {bus.sel_in, bus.sample};
`else
  assign word = bus.sample;
`endif

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    wr_d    = 1'b0;
    fs_d    = 1'b0;
    data_d  = data_q;
    start   = 1'b0;
    ovr_set = 1'b0;
    seq_set = 1'b0;
    cnt_inc = 1'b0;
    // A sweep already running when reset is released is ignored until req_data drops.
    armed_d = armed_q | ~bus.req_data;

    case (state_q)
      IDLE: begin
        if (armed_q && bus.req_data) begin
          if (bus.sel_in == 3'd0) begin
            start = 1'b1;
          end else begin
            seq_set = 1'b1;
            state_d = DROP;
          end
        end
      end
      COLLECT: begin
        if (!bus.req_data) begin
          seq_set = 1'b1;
          exp_d   = 3'd0;
          state_d = IDLE;
        end else if (bus.sel_in == exp_q) begin
          if (bus.fifo_full) begin
            ovr_set = 1'b1;
            exp_d   = 3'd0;
            state_d = DROP;
          end else begin
            wr_d   = 1'b1;
            data_d = word;
            if (exp_q == channels) begin
              cnt_inc = 1'b1;
              exp_d   = 3'd0;
              state_d = IDLE;
            end else begin
              exp_d = exp_q + 3'd1;
            end
          end
        end else if (bus.sel_in == 3'd0) begin
          seq_set = 1'b1;
          start   = 1'b1;
        end else begin
          seq_set = 1'b1;
          exp_d   = 3'd0;
          state_d = DROP;
        end
      end
      DROP: begin
        if (!bus.req_data) begin
          state_d = IDLE;
        end else if (bus.sel_in == 3'd0) begin
          seq_set = 1'b1;
          start   = 1'b1;
        end
      end
      default: begin
        exp_d   = 3'd0;
        state_d = IDLE;
      end
    endcase

    // Frame start shared by IDLE and by restarts out of COLLECT/DROP.
    if (start) begin
      exp_d = 3'd0;
      if (bus.fifo_full) begin
        ovr_set = 1'b1;
        state_d = DROP;
      end else begin
        wr_d   = 1'b1;
        fs_d   = 1'b1;
        data_d = word;
        if (channels == 3'd0) begin
          cnt_inc = 1'b1;
          state_d = IDLE;
        end else begin
          exp_d   = 3'd1;
          state_d = COLLECT;
        end
      end
    end

    ovr_d = ovr_set | (ovr_q & ~err_clr);
    seq_d = seq_set | (seq_q & ~err_clr);
    cnt_d = cnt_q + CNT_W'(cnt_inc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      exp_q   <= 3'd0;
      armed_q <= 1'b0;
      wr_q    <= 1'b0;
      fs_q    <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      seq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      armed_q <= armed_d;
      wr_q    <= wr_d;
      fs_q    <= fs_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fifo_wr     = wr_q;
  assign bus.fifo_data   = data_q;
  assign bus.frame_start = fs_q;
  assign overrun         = ovr_q;
  assign seq_err         = seq_q;
  assign frame_count     = cnt_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_ch_collect.sv
// Directed bench for ch_collect: inputs driven on the falling edge, writes logged on the falling edge.
module tb_ch_collect;
  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
`ifdef CH_COLLECT_TAG_EN
  localparam int DW = WIDTH + 3;
`else
  localparam int DW = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       channels = 3'd0;
  logic             err_clr = 1'b0;
  logic             overrun, seq_err;
  logic [CNT_W-1:0] frame_count;
  logic [1:0]       dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];
  int          got_cyc[$];

  ch_collect_if #(.WIDTH(WIDTH)) bus();

  ch_collect #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .channels    (channels),
    .err_clr     (err_clr),
    .bus         (bus),
    .overrun     (overrun),
    .seq_err     (seq_err),
    .frame_count (frame_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write monitor: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (bus.fifo_wr === 1'b1) begin
      got_q.push_back({bus.frame_start, bus.fifo_data});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] exp_word(input logic [2:0] ch, input logic [WIDTH-1:0] s);
`ifdef CH_COLLECT_TAG_EN
    return {ch, s};
`else
    return s;
`endif
  endfunction

  // driver tasks
  task automatic drive(input logic rq, input logic [2:0] s, input logic [WIDTH-1:0] smp,
                       input logic full, input logic clr);
    @(negedge clk);
    bus.req_data  = rq;
    bus.sel_in    = s;
    bus.sample    = smp;
    bus.fifo_full = full;
    err_clr       = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic sweep(input logic [2:0] last, input logic [WIDTH-1:0] base, input int full_at);
    for (int i = 0; i <= int'(last); i++)
      drive(1'b1, 3'(i), base + WIDTH'(i), (i == full_at), 1'b0);
    idle(3);
  endtask

  task automatic drain(input string name);
    logic [DW:0] e, g;
    total_cnt++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL %s_word got=%0h exp=%0h", name, g, e);
      else pass_cnt++;
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.fifo_wr !== 1'b0) $display("FAIL reset_fifo_wr got=%0h exp=0", bus.fifo_wr); else pass_cnt++;
    total_cnt++; if (bus.fifo_data !== '0) $display("FAIL reset_fifo_data got=%0h exp=0", bus.fifo_data); else pass_cnt++;
    total_cnt++; if (bus.frame_start !== 1'b0) $display("FAIL reset_frame_start got=%0h exp=0", bus.frame_start); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%0h exp=0", overrun); else pass_cnt++;
    total_cnt++; if (seq_err !== 1'b0) $display("FAIL reset_seq_err got=%0h exp=0", seq_err); else pass_cnt++;
    total_cnt++; if (frame_count !== '0) $display("FAIL reset_frame_count got=%0h exp=0", frame_count); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0h exp=0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_normal();
    channels = 3'd3;
    sweep(3'd3, 16'h1000, -1);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), exp_word(3'(i), 16'h1000 + 16'(i))});
    total_cnt++;
    if (got_cyc.size() != 4 || got_cyc[3] - got_cyc[0] != 3)
      $display("FAIL normal_back_to_back got=%0d writes exp=4 consecutive", got_cyc.size());
    else pass_cnt++;
    drain("normal");
    total_cnt++; if (frame_count !== 16'd1) $display("FAIL normal_frame_count got=%0d exp=1", frame_count); else pass_cnt++;
    total_cnt++; if ({overrun, seq_err} !== 2'b00) $display("FAIL normal_flags got=%b exp=00", {overrun, seq_err}); else pass_cnt++;
  endtask

  task automatic test_single();
    channels = 3'd0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 16'h2000 + 16'(k), 1'b0, 1'b0);
      idle(3);
      exp_q.push_back({1'b1, exp_word(3'd0, 16'h2000 + 16'(k))});
    end
    drain("single");
    total_cnt++; if (frame_count !== 16'd4) $display("FAIL single_frame_count got=%0d exp=4", frame_count); else pass_cnt++;
  endtask

  task automatic test_overrun();
    channels = 3'd3;
    sweep(3'd3, 16'h3000, 2);
    exp_q.push_back({1'b1, exp_word(3'd0, 16'h3000)});
    exp_q.push_back({1'b0, exp_word(3'd1, 16'h3001)});
    drain("overrun_trunc");
    total_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_flag got=%0h exp=1", overrun); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd4) $display("FAIL overrun_count_hold got=%0d exp=4", frame_count); else pass_cnt++;
    sweep(3'd3, 16'h3100, -1);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), exp_word(3'(i), 16'h3100 + 16'(i))});
    drain("overrun_clean");
    total_cnt++; if (frame_count !== 16'd5) $display("FAIL overrun_count_next got=%0d exp=5", frame_count); else pass_cnt++;
    drive(1'b0, 3'd0, '0, 1'b0, 1'b1);
    idle(1);
    total_cnt++; if (overrun !== 1'b0) $display("FAIL overrun_clear got=%0h exp=0", overrun); else pass_cnt++;
  endtask

  task automatic test_seq_err();
    channels = 3'd3;
    drive(1'b1, 3'd0, 16'h4000, 1'b0, 1'b0);
    drive(1'b1, 3'd2, 16'h4002, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 16'h4003, 1'b0, 1'b0);
    idle(3);
    exp_q.push_back({1'b1, exp_word(3'd0, 16'h4000)});
    drain("seq_skip");
    total_cnt++; if (seq_err !== 1'b1) $display("FAIL seq_flag got=%0h exp=1", seq_err); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd5) $display("FAIL seq_count_hold got=%0d exp=5", frame_count); else pass_cnt++;
    drive(1'b0, 3'd0, '0, 1'b0, 1'b1);
    idle(1);
    total_cnt++; if (seq_err !== 1'b0) $display("FAIL seq_clear got=%0h exp=0", seq_err); else pass_cnt++;
  endtask

  task automatic test_restart();
    channels = 3'd3;
    drive(1'b1, 3'd0, 16'h5000, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 16'h5001, 1'b0, 1'b0);
    // restart while exp=2, with err_clr in the same cycle: set must win
    drive(1'b1, 3'd0, 16'h5100, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) drive(1'b1, 3'(i), 16'h5100 + 16'(i), 1'b0, 1'b0);
    idle(3);
    exp_q.push_back({1'b1, exp_word(3'd0, 16'h5000)});
    exp_q.push_back({1'b0, exp_word(3'd1, 16'h5001)});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), exp_word(3'(i), 16'h5100 + 16'(i))});
    drain("restart");
    total_cnt++; if (seq_err !== 1'b1) $display("FAIL restart_seq_err got=%0h exp=1", seq_err); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd6) $display("FAIL restart_frame_count got=%0d exp=6", frame_count); else pass_cnt++;
    drive(1'b0, 3'd0, '0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic test_reset_mid();
    channels = 3'd3;
    drive(1'b1, 3'd0, 16'h6000, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 16'h6001, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    total_cnt++; if (bus.fifo_wr !== 1'b0) $display("FAIL midrst_fifo_wr got=%0h exp=0", bus.fifo_wr); else pass_cnt++;
    total_cnt++; if (bus.fifo_data !== '0) $display("FAIL midrst_fifo_data got=%0h exp=0", bus.fifo_data); else pass_cnt++;
    total_cnt++; if (frame_count !== '0) $display("FAIL midrst_frame_count got=%0d exp=0", frame_count); else pass_cnt++;
    drive(1'b1, 3'd2, 16'h6002, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 3'd3, 16'h6003, 1'b0, 1'b0);
    idle(3);
    exp_q.push_back({1'b1, exp_word(3'd0, 16'h6000)});
    drain("midrst_ignore");
    total_cnt++; if ({overrun, seq_err} !== 2'b00) $display("FAIL midrst_flags got=%b exp=00", {overrun, seq_err}); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL midrst_state got=%0h exp=0", dbg_state); else pass_cnt++;
    sweep(3'd3, 16'h7000, -1);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), exp_word(3'(i), 16'h7000 + 16'(i))});
    drain("midrst_next");
    total_cnt++; if (frame_count !== 16'd1) $display("FAIL midrst_next_count got=%0d exp=1", frame_count); else pass_cnt++;
  endtask

  initial begin
    bus.req_data  = 1'b0;
    bus.sel_in    = 3'd0;
    bus.sample    = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_normal();
    test_single();
    test_overrun();
    test_seq_err();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ch_collect.md
# ch_collect

Receive-side partner of the channel selector. It consumes the selector's `req_data`/`sel` sweep and the muxed sample bus, captures exactly one sample per channel index 0..`channels` per strobe, and writes them in order into the downstream sample FIFO. It checks each sweep for sequence errors and FIFO overruns, and keeps frames aligned by discarding the remainder of any frame that cannot be written whole.

## Interface
Parameters:
- `WIDTH`, 16: sample and FIFO word width.
- `CNT_W`, 16: width of the completed-frame counter.

Ports:
- `clk` in 1: sole clock. The selector drives `sel_in`/`req_data` on the falling edge; this block samples on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `channels` in 3: last channel index; frame length is `channels`+1. Must be static while not idle.
- `req_data` in 1: selector sweep active.
- `sel_in` in 3: channel index currently presented on `sample`.
- `sample` in WIDTH: muxed sample for `sel_in`, valid in the same cycle.
- `fifo_full` in 1: downstream FIFO cannot accept a write this cycle.
- `err_clr` in 1: clears `overrun` and `seq_err`.
- `fifo_wr` out 1: write strobe, one cycle per word.
- `fifo_data` out WIDTH (WIDTH+3 with tag): word to write.
- `frame_start` out 1: qualifies `fifo_wr` on channel 0 of a frame.
- `overrun` out 1: sticky; a frame was truncated by `fifo_full`.
- `seq_err` out 1: sticky; a sweep was malformed.
- `frame_count` out CNT_W: count of frames written completely.

## Operation
- Reset values: state IDLE, `exp`=0, `fifo_wr`=0, `fifo_data`=0, `frame_start`=0, `overrun`=0, `seq_err`=0, `frame_count`=0.
- "Hit" condition: `req_data`=1 and `sel_in`=`exp`. On a hit, the sample is written when `fifo_full`=0.

States:
- **IDLE** (`exp`=0):
  - `req_data` and `sel_in`=0 with `fifo_full`=0: write with `frame_start`=1.
    - If `channels`=0: the frame is complete; increment `frame_count` and stay in IDLE.
    - Otherwise: set `exp`=1 and go to COLLECT.
  - `req_data` and `sel_in`=0 with `fifo_full`=1: set `overrun`; go to DROP.
  - `req_data` with `sel_in`≠0: set `seq_err`; go to DROP.
- **COLLECT**:
  - Hit with `fifo_full`=0: write and increment `exp`.
    - If `exp`=`channels`: increment `frame_count`, set `exp`=0, go to IDLE.
  - Hit with `fifo_full`=1: drop the word, set `overrun`, go to DROP.
  - `req_data`=0 (early end): set `seq_err`, go to IDLE.
  - `sel_in`=0 with `req_data` (restart by a new strobe): set `seq_err`, then handle the cycle as an IDLE frame start in the same cycle.
  - Any other `sel_in`≠`exp`: set `seq_err`, go to DROP.
- **DROP**: discard everything. Return to IDLE on the first cycle with `req_data`=0. `sel_in`=0 with `req_data` is a restart and is handled as in COLLECT.
- `frame_count` wraps modulo 2^CNT_W.
- `err_clr` clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- A truncated frame never increments `frame_count`. Words already written for it remain in the FIFO; downstream realigns on `frame_start`.

## Timing
- Latency is 1 cycle: the hit is sampled at edge N, and `fifo_wr`, `fifo_data` and `frame_start` are registered and valid during cycle N+1.
- `fifo_full` is sampled at the same edge as the hit.
- At most one write per cycle; back-to-back writes are required at full sweep rate, giving `channels`+1 consecutive `fifo_wr` pulses per frame.
- `overrun`, `seq_err` and `frame_count` update at the same edge the triggering event is sampled.
- `reset_n` asserted mid-frame clears all state immediately. Sweeps in progress at deassertion are ignored until `req_data` has been seen low (treated as DROP).

## Configuration
- `CH_COLLECT_TAG_EN` defined: `fifo_data` is WIDTH+3 bits, with `{sel_in, sample}` registered together so the upper 3 bits carry the channel index.
- `CH_COLLECT_TAG_EN` undefined: `fifo_data` is WIDTH bits and holds the sample only. No other behaviour changes.

## Test plan
- **Normal sweep**: `channels`=3, one strobe, samples 0x1000..0x1003 → four consecutive `fifo_wr`, data 0x1000..0x1003, `frame_start` on the first, `frame_count`=1, no flags.
- **Single channel**: `channels`=0, three strobes spaced 4 cycles → three writes, each with `frame_start`; `frame_count`=3.
- **Overrun**: `channels`=3, `fifo_full` asserted during `sel_in`=2 → only words 0 and 1 written, `overrun`=1, `frame_count` unchanged. The next clean sweep writes 4 words and `frame_count` increments.
- **Sequence error**: `sel_in` skips 1 (0,2,3) → word 0 written, `seq_err`=1, no further writes that sweep. Then `err_clr` clears the flag.
- **Restart**: new strobe restarts at `sel_in`=0 while `exp`=2 → `seq_err`=1 and a fresh `frame_start` write of the new channel 0 in the same cycle.
- **Reset mid-frame and tag**: `reset_n` low at `sel_in`=1 and released at `sel_in`=2 → all outputs at reset values and no writes until the next sweep. With `CH_COLLECT_TAG_EN`, `fifo_data[WIDTH+2:WIDTH]` matches the channel index of each write.
